// File: rtl/led_status_pkg.sv
// Shared sizing helpers and the blink pattern rule for the multi-channel LED status indicator.
package led_status_pkg;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  function automatic int max_code(input int state_w);
    return (1 << state_w) - 1;
  endfunction

  function automatic int num_slots(input int gap, input int state_w);
    return gap + 2 * max_code(state_w);
  endfunction

  // Code k lights slots gap, gap+2, ..., gap+2k; the all-ones code lights every slot.
  function automatic logic blink_on(input int slot, input int code, input int gap, input int mx);
    int d;
    if (code == mx) return 1'b1;
    if (slot < gap) return 1'b0;
    d = slot - gap;
    return (d[0] == 1'b0) && ((d >>> 1) <= code);
  endfunction

endpackage

// File: rtl/led_frame_timer.sv
// Shared prescaler and slot counter; flags the frame-wrap clock and emits a registered frame strobe.
module led_frame_timer
  import led_status_pkg::*;
#(
  parameter int TICK_DIV = 4,
  parameter int SLOTS    = 16,
  parameter int SLOT_W   = 4
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              en,
  output logic [SLOT_W-1:0] slot,
  output logic              frame_wrap,
  output logic              frame_sync
);

  localparam int DIV_W = (TICK_DIV > 1) ? clog2(TICK_DIV) : 1;

  logic [DIV_W-1:0] div_cnt;
  logic             tick;

  assign tick       = (div_cnt == DIV_W'(TICK_DIV - 1));
  assign frame_wrap = tick && (slot == SLOT_W'(SLOTS - 1));

  // A disabled timer sits exactly in its reset state so re-enabling starts a fresh frame.
  always_ff @(posedge Clk) begin
    if (Rst || !en) begin
      div_cnt    <= '0;
      slot       <= '0;
      frame_sync <= 1'b0;
    end else begin
      frame_sync <= frame_wrap;
      if (tick) begin
        div_cnt <= '0;
        slot    <= frame_wrap ? '0 : slot + SLOT_W'(1);
      end else begin
        div_cnt <= div_cnt + DIV_W'(1);
      end
    end
  end

endmodule

// File: rtl/led_status_multi.sv
// Multi-channel LED status indicator: each channel blinks its latched code once per frame.
module led_status_multi
  import led_status_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int STATE_W    = 2,
  parameter int TICK_DIV   = 4,
  parameter int GAP_SLOTS  = 10,
  parameter int ACTIVE_LOW = 0
) (
  input  logic                      Clk,
  input  logic                      Rst,
  input  logic                      en,
  input  logic [NUM_CH*STATE_W-1:0] state,
  output logic [NUM_CH-1:0]         led,
  output logic                      frame_sync
);

  localparam int   MAX_CODE = max_code(STATE_W);
  localparam int   SLOTS    = num_slots(GAP_SLOTS, STATE_W);
  localparam int   SLOT_W   = clog2(SLOTS);
  localparam logic INACTIVE = (ACTIVE_LOW != 0);

  logic [SLOT_W-1:0] slot;
  logic              frame_wrap;

  led_frame_timer #(
    .TICK_DIV(TICK_DIV),
    .SLOTS   (SLOTS),
    .SLOT_W  (SLOT_W)
  ) timer (
    .Clk       (Clk),
    .Rst       (Rst),
    .en        (en),
    .slot      (slot),
    .frame_wrap(frame_wrap),
    .frame_sync(frame_sync)
  );

  for (genvar c = 0; c < NUM_CH; c++) begin : ch
    logic [STATE_W-1:0] lat;
    logic               on;
    logic               led_q;

    always_comb on = blink_on(int'(slot), int'(lat), GAP_SLOTS, MAX_CODE);

    // The code is captured only on the wrap clock so a burst is never torn mid-frame.
    always_ff @(posedge Clk) begin
      if (Rst || !en) begin
        lat   <= '0;
        led_q <= INACTIVE;
      end else begin
        if (frame_wrap) lat <= state[c*STATE_W +: STATE_W];
        led_q <= on ^ INACTIVE;
      end
    end

    assign led[c] = led_q;
  end

endmodule
